vend_change_dispenser: RTL

- Consumes the 2-bit change code produced by the vending FSM each cycle and turns it into physical coin ejections.
- Accumulates pending change in 5-unit credits and drives a two-tube coin hopper (5-unit and 10-unit tubes) through a 4-phase req/ack handshake.
- Sits between the vending FSM's change output and the hopper controller, with timeout and empty-tube fault reporting.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_timeout_ctr.sv | 39 +++
 rtl/vend_change_dispenser.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared encodings for the vending change path: change codes, dispenser
// FSM states and fault causes.
package vend_pkg;

  localparam logic [1:0] CHA_NONE = 2'b00;
  localparam logic [1:0] CHA_5    = 2'b01;
  localparam logic [1:0] CHA_10   = 2'b10;
  localparam logic [1:0] CHA_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_NOCOIN  = 2'b10;

  // Credits (5-unit steps) carried by a change code; the illegal code adds nothing.
  function automatic logic [1:0] cha_credits(input logic [1:0] cha);
    case (cha)
      CHA_5:   cha_credits = 2'd1;
      CHA_10:  cha_credits = 2'd2;
      default: cha_credits = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Loadable/clearable cycle counter; expire flags the increment that
// would bring the count to TIMEOUT.
module vend_timeout_ctr #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [TO_W-1:0] load_val,
  input  logic            inc,
  output logic            expire
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire = inc && (cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Turns change codes from the vending FSM into coin ejections on a
// two-tube hopper, with pending-credit accounting and fault reporting.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cha,
  input  logic             eject_ack,
  input  logic             hop5_empty,
  input  logic             hop10_empty,
  input  logic             fault_clr,
  output logic             eject_req,
  output logic             coin_sel,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic             err,
  output state_e           dbg_state
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << CNT_W) - 1);

  state_e           state_q, state_d;
  logic             eject_req_q, eject_req_d;
  logic             coin_sel_q, coin_sel_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             err_q, err_d;
  logic [1:0]       add_cr, sub_cr;
  logic [SUM_W-1:0] sum;
  logic             sat;
  logic             to_clr, to_inc, to_expire;

  vend_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_to (
    .clk      (clk),
    .rst      (rst),
    .clr      (to_clr),
    .load     (1'b0),
    .load_val ({TO_W{1'b0}}),
    .inc      (to_inc),
    .expire   (to_expire)
  );

  // Hopper handshake (4-phase): eject_req rises with coin_sel stable; the
  // hopper raises eject_ack once the coin is out (credit is taken then);
  // eject_req falls, and the next coin waits until eject_ack has fallen.
  // Each phase is bounded by the timeout counter.
  always_comb begin
    state_d      = state_q;
    eject_req_d  = eject_req_q;
    coin_sel_d   = coin_sel_q;
    fault_code_d = fault_code_q;
    sub_cr       = 2'd0;
    to_clr       = 1'b0;
    to_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        to_clr = 1'b1;
        if (pending_q != '0) begin
          if (pending_q >= CNT_W'(2) && !hop10_empty) begin
            coin_sel_d  = 1'b1;
            eject_req_d = 1'b1;
            state_d     = ST_REQ;
          end else if (!hop5_empty) begin
            coin_sel_d  = 1'b0;
            eject_req_d = 1'b1;
            state_d     = ST_REQ;
          end else begin
            fault_code_d = FC_NOCOIN;
            state_d      = ST_FAULT;
          end
        end
      end
      ST_REQ: begin
        to_inc = 1'b1;
        if (to_expire) begin
          fault_code_d = FC_TIMEOUT;
          eject_req_d  = 1'b0;
          state_d      = ST_FAULT;
        end else if (eject_ack) begin
          sub_cr      = coin_sel_q ? 2'd2 : 2'd1;
          to_clr      = 1'b1;
          eject_req_d = 1'b0;
          state_d     = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        to_inc = 1'b1;
        if (to_expire) begin
          fault_code_d = FC_TIMEOUT;
          state_d      = ST_FAULT;
        end else if (!eject_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        to_clr = 1'b1;
        if (fault_clr) begin
          fault_code_d = FC_NONE;
          state_d      = ST_IDLE;
        end
      end
    endcase

    // Add and subtract land in the same cycle; overflow clamps and flags err.
    add_cr = cha_credits(cha);
    sum    = SUM_W'(pending_q) + SUM_W'(add_cr) - SUM_W'(sub_cr);
    sat    = (sum > PEND_MAX);
    if (sat) begin
      pending_d = PEND_MAX[CNT_W-1:0];
    end else begin
      pending_d = sum[CNT_W-1:0];
    end
    err_d = err_q | sat | (cha == CHA_ILL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      eject_req_q  <= 1'b0;
      coin_sel_q   <= 1'b0;
      fault_code_q <= FC_NONE;
      pending_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      eject_req_q  <= eject_req_d;
      coin_sel_q   <= coin_sel_d;
      fault_code_q <= fault_code_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
    end
  end

  assign eject_req  = eject_req_q;
  assign coin_sel   = coin_sel_q;
  assign pending    = pending_q;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_IDLE) || (pending_q != '0);
  assign dbg_state  = state_q;

endmodule
